// File: rtl/t05_least_pair_scanner.sv
// t05_least_pair_scanner: finds the two smallest live counts in a count
// memory behind a fixed-latency read port, then strobes both for retirement.
module t05_least_pair_scanner #(
  parameter  int DEPTH  = 512,
  parameter  int CNT_W  = 32,
  parameter  int RD_LAT = 1,
  localparam int IDX_W  = $clog2(DEPTH)
) (
  input  logic             i_clk,
  input  logic             i_nrst,
  input  logic             i_en,
  input  logic             i_start,
  input  logic             i_zero_skip,
  output logic             o_rd_en,
  output logic [IDX_W-1:0] o_rd_addr,
  input  logic [CNT_W-1:0] i_rd_data,
  input  logic             i_rd_live,
  output logic             o_wipe_en,
  output logic [IDX_W-1:0] o_wipe_addr,
  output logic [IDX_W-1:0] o_least1_idx,
  output logic [IDX_W-1:0] o_least2_idx,
  output logic [CNT_W-1:0] o_least1_val,
  output logic [CNT_W-1:0] o_least2_val,
  output logic [CNT_W:0]   o_sum,
  output logic [IDX_W:0]   o_live_cnt,
  output logic             o_single,
  output logic             o_busy,
  output logic             o_done
);

  localparam int LW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_DRAIN,
    S_WIPE1,
    S_WIPE2,
    S_DONE
  } state_t;

  state_t r_state;
  state_t w_nxt;

  logic [IDX_W:0]   r_cnt;
  logic [LW-1:0]    r_dcnt;
  logic             r_zskip;
  logic [RD_LAT-1:0]            r_pv;
  logic [RD_LAT-1:0][IDX_W-1:0] r_pa;
  logic [RD_LAT-1:0]            w_pv_sh;
  logic [RD_LAT-1:0][IDX_W-1:0] w_pa_sh;

  logic [IDX_W-1:0] r_l1_idx, r_l2_idx;
  logic [CNT_W-1:0] r_l1_val, r_l2_val;
  logic [CNT_W:0]   r_sum;
  logic [IDX_W:0]   r_live_cnt;
  logic             r_single;

  logic             r_rd_en, r_wipe_en, r_busy, r_done;
  logic [IDX_W-1:0] r_rd_addr, r_wipe_addr;

  logic             w_start, w_last, w_issue, w_hit;
  logic [IDX_W-1:0] w_ra;
  logic [IDX_W-1:0] w_l1_idx, w_l2_idx;
  logic [CNT_W-1:0] w_l1_val, w_l2_val;
  logic [IDX_W:0]   w_live_cnt;
  logic             w_rd_en, w_wipe_en, w_busy, w_done;
  logic [IDX_W-1:0] w_rd_addr, w_wipe_addr;

  assign w_start = i_en && i_start && (r_state == S_IDLE);
  assign w_last  = (r_cnt == (IDX_W+1)'(DEPTH));
  assign w_issue = i_en && (r_state == S_READ) && !w_last;

  // Return pipeline runs free of en so in-flight reads always land.
  if (RD_LAT == 1) begin : g_lat1
    assign w_pv_sh = r_rd_en;
    assign w_pa_sh = r_rd_addr;
  end else begin : g_latn
    assign w_pv_sh = {r_pv[RD_LAT-2:0], r_rd_en};
    assign w_pa_sh = {r_pa[RD_LAT-2:0], r_rd_addr};
  end

  assign w_ra  = r_pa[RD_LAT-1];
  assign w_hit = r_pv[RD_LAT-1] && i_rd_live &&
                 !(r_zskip && (i_rd_data == '0));

  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_nxt;
    end
  end

  always_comb begin
    w_nxt = r_state;
    if (i_en) begin
      unique case (r_state)
        S_IDLE:  if (i_start) w_nxt = S_READ;
        S_READ:  if (w_last) w_nxt = S_DRAIN;
        S_DRAIN: if (r_dcnt == LW'(RD_LAT-1)) w_nxt = S_WIPE1;
        S_WIPE1: w_nxt = S_WIPE2;
        S_WIPE2: w_nxt = S_DONE;
        S_DONE:  w_nxt = S_IDLE;
        default: w_nxt = S_IDLE;
      endcase
    end
  end

  always_comb begin
    w_l1_idx   = r_l1_idx;
    w_l1_val   = r_l1_val;
    w_l2_idx   = r_l2_idx;
    w_l2_val   = r_l2_val;
    w_live_cnt = r_live_cnt;
    if (w_hit) begin
      w_live_cnt = r_live_cnt + 1'b1;
      if (r_live_cnt == '0 || i_rd_data < r_l1_val) begin
        w_l2_idx = r_l1_idx;
        w_l2_val = r_l1_val;
        w_l1_idx = w_ra;
        w_l1_val = i_rd_data;
      end else if (r_live_cnt == (IDX_W+1)'(1) ||
                   i_rd_data < r_l2_val) begin
        w_l2_idx = w_ra;
        w_l2_val = i_rd_data;
      end
    end
  end

  always_comb begin
    w_rd_en     = i_en && (w_nxt == S_READ);
    w_rd_addr   = r_rd_addr;
    w_wipe_en   = 1'b0;
    w_wipe_addr = r_wipe_addr;
    w_done      = 1'b0;
    w_busy      = (w_nxt != S_IDLE);
    if (w_start) begin
      w_rd_addr = '0;
    end else if (w_issue) begin
      w_rd_addr = r_cnt[IDX_W-1:0];
    end
    // Strobes fire on state entry so a stalled state never repeats them.
    if (i_en) begin
      unique case (r_state)
        S_DRAIN: begin
          if (w_nxt == S_WIPE1) begin
            w_wipe_en   = (w_live_cnt != '0);
            w_wipe_addr = w_l1_idx;
          end
        end
        S_WIPE1: begin
          w_wipe_en   = (r_live_cnt >= (IDX_W+1)'(2));
          w_wipe_addr = r_l2_idx;
        end
        S_WIPE2: w_done = 1'b1;
        default: w_done = 1'b0;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      r_rd_en     <= 1'b0;
      r_rd_addr   <= '0;
      r_wipe_en   <= 1'b0;
      r_wipe_addr <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_rd_en     <= w_rd_en;
      r_rd_addr   <= w_rd_addr;
      r_wipe_en   <= w_wipe_en;
      r_wipe_addr <= w_wipe_addr;
      r_busy      <= w_busy;
      r_done      <= w_done;
    end
  end

  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      r_cnt  <= '0;
      r_dcnt <= '0;
      r_pv   <= '0;
      r_pa   <= '0;
    end else begin
      r_pv <= w_pv_sh;
      r_pa <= w_pa_sh;
      if (w_start) begin
        r_cnt <= (IDX_W+1)'(1);
      end else if (w_issue) begin
        r_cnt <= r_cnt + 1'b1;
      end
      if (i_en && r_state == S_READ) begin
        r_dcnt <= '0;
      end else if (i_en && r_state == S_DRAIN) begin
        r_dcnt <= r_dcnt + 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      r_zskip    <= 1'b0;
      r_l1_idx   <= '1;
      r_l1_val   <= '1;
      r_l2_idx   <= '1;
      r_l2_val   <= '1;
      r_sum      <= '0;
      r_live_cnt <= '0;
      r_single   <= 1'b0;
    end else if (w_start) begin
      r_zskip    <= i_zero_skip;
      r_l1_idx   <= '1;
      r_l1_val   <= '1;
      r_l2_idx   <= '1;
      r_l2_val   <= '1;
      r_sum      <= '0;
      r_live_cnt <= '0;
      r_single   <= 1'b0;
    end else begin
      r_l1_idx   <= w_l1_idx;
      r_l1_val   <= w_l1_val;
      r_l2_idx   <= w_l2_idx;
      r_l2_val   <= w_l2_val;
      r_live_cnt <= w_live_cnt;
      if (i_en && r_state == S_WIPE2) begin
        r_single <= (r_live_cnt == (IDX_W+1)'(1));
        if (r_live_cnt >= (IDX_W+1)'(2)) begin
          r_sum <= {1'b0, r_l1_val} + {1'b0, r_l2_val};
        end else if (r_live_cnt == (IDX_W+1)'(1)) begin
          r_sum <= {1'b0, r_l1_val};
        end else begin
          r_sum <= '0;
        end
      end
    end
  end

  assign o_rd_en      = r_rd_en;
  assign o_rd_addr    = r_rd_addr;
  assign o_wipe_en    = r_wipe_en;
  assign o_wipe_addr  = r_wipe_addr;
  assign o_least1_idx = r_l1_idx;
  assign o_least2_idx = r_l2_idx;
  assign o_least1_val = r_l1_val;
  assign o_least2_val = r_l2_val;
  assign o_sum        = r_sum;
  assign o_live_cnt   = r_live_cnt;
  assign o_single     = r_single;
  assign o_busy       = r_busy;
  assign o_done       = r_done;

endmodule

// File: tb/tb_t05_least_pair_scanner.sv
// Bench for t05_least_pair_scanner: two instances (read latency 1 and 3)
// over an 8-entry count memory model, driven by a table of scans.
module tb_t05_least_pair_scanner;

  localparam int DEPTH = 8;
  localparam int CW    = 32;
  localparam int IW    = 3;

  typedef struct {
    bit                   dut;
    bit                   drop;
    bit                   zs;
    logic [7:0][CW-1:0]   cnt;
    logic [7:0]           live;
    int                   l1i;
    logic [CW-1:0]        l1v;
    int                   l2i;
    logic [CW-1:0]        l2v;
    logic [63:0]          sum;
    int                   lc;
    bit                   single;
    int                   nw;
    int                   w0;
    int                   w1;
    int                   done;
  } vec_t;

  logic clk, nrst, en, zs, start0, start1;
  logic [7:0][CW-1:0] mem;
  logic [7:0]         mlive;

  logic          rd_en0, rd_en1, wipe_en0, wipe_en1;
  logic [IW-1:0] rd_addr0, rd_addr1, wipe_addr0, wipe_addr1;
  logic [IW-1:0] l1i0, l1i1, l2i0, l2i1;
  logic [CW-1:0] l1v0, l1v1, l2v0, l2v1, rd_data0, rd_data1;
  logic [CW:0]   sum0, sum1;
  logic [IW:0]   lc0, lc1;
  logic          rd_live0, rd_live1;
  logic          single0, single1, busy0, busy1, done0, done1;

  logic          sel;
  logic          s_rd_en, s_wipe_en, s_single, s_busy, s_done;
  logic [IW-1:0] s_rd_addr, s_wipe_addr, s_l1i, s_l2i;
  logic [CW-1:0] s_l1v, s_l2v;
  logic [CW:0]   s_sum;
  logic [IW:0]   s_lc;

  int checks = 0;
  int failures = 0;
  vec_t vt[8];

  t05_least_pair_scanner #(.DEPTH(DEPTH), .CNT_W(CW), .RD_LAT(1)) u0 (
    .i_clk(clk), .i_nrst(nrst), .i_en(en), .i_start(start0),
    .i_zero_skip(zs), .o_rd_en(rd_en0), .o_rd_addr(rd_addr0),
    .i_rd_data(rd_data0), .i_rd_live(rd_live0),
    .o_wipe_en(wipe_en0), .o_wipe_addr(wipe_addr0),
    .o_least1_idx(l1i0), .o_least2_idx(l2i0),
    .o_least1_val(l1v0), .o_least2_val(l2v0),
    .o_sum(sum0), .o_live_cnt(lc0), .o_single(single0),
    .o_busy(busy0), .o_done(done0));

  t05_least_pair_scanner #(.DEPTH(DEPTH), .CNT_W(CW), .RD_LAT(3)) u1 (
    .i_clk(clk), .i_nrst(nrst), .i_en(en), .i_start(start1),
    .i_zero_skip(zs), .o_rd_en(rd_en1), .o_rd_addr(rd_addr1),
    .i_rd_data(rd_data1), .i_rd_live(rd_live1),
    .o_wipe_en(wipe_en1), .o_wipe_addr(wipe_addr1),
    .o_least1_idx(l1i1), .o_least2_idx(l2i1),
    .o_least1_val(l1v1), .o_least2_val(l2v1),
    .o_sum(sum1), .o_live_cnt(lc1), .o_single(single1),
    .o_busy(busy1), .o_done(done1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory models; garbage is driven when no read is returning.
  logic          m0_v;
  logic [IW-1:0] m0_a;
  logic [2:0]    m1_v;
  logic [2:0][IW-1:0] m1_a;

  always @(posedge clk) begin
    m0_v <= rd_en0;
    m0_a <= rd_addr0;
    m1_v <= {m1_v[1:0], rd_en1};
    m1_a <= {m1_a[1:0], rd_addr1};
  end

  assign rd_data0 = m0_v ? mem[m0_a] : 32'hDEADBEEF;
  assign rd_live0 = m0_v ? mlive[m0_a] : 1'b1;
  assign rd_data1 = m1_v[2] ? mem[m1_a[2]] : 32'hDEADBEEF;
  assign rd_live1 = m1_v[2] ? mlive[m1_a[2]] : 1'b1;

  always_comb begin
    s_rd_en = rd_en0; s_rd_addr = rd_addr0;
    s_wipe_en = wipe_en0; s_wipe_addr = wipe_addr0;
    s_l1i = l1i0; s_l2i = l2i0; s_l1v = l1v0; s_l2v = l2v0;
    s_sum = sum0; s_lc = lc0; s_single = single0;
    s_busy = busy0; s_done = done0;
    if (sel) begin
      s_rd_en = rd_en1; s_rd_addr = rd_addr1;
      s_wipe_en = wipe_en1; s_wipe_addr = wipe_addr1;
      s_l1i = l1i1; s_l2i = l2i1; s_l1v = l1v1; s_l2v = l2v1;
      s_sum = sum1; s_lc = lc1; s_single = single1;
      s_busy = busy1; s_done = done1;
    end
  end

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, " rd_en"}, 64'(s_rd_en), 64'd0);
    chk({tag, " wipe_en"}, 64'(s_wipe_en), 64'd0);
    chk({tag, " busy"}, 64'(s_busy), 64'd0);
    chk({tag, " done"}, 64'(s_done), 64'd0);
    chk({tag, " l1i"}, 64'(s_l1i), 64'd7);
    chk({tag, " l1v"}, 64'(s_l1v), 64'hFFFFFFFF);
    chk({tag, " l2i"}, 64'(s_l2i), 64'd7);
    chk({tag, " l2v"}, 64'(s_l2v), 64'hFFFFFFFF);
    chk({tag, " sum"}, 64'(s_sum), 64'd0);
    chk({tag, " live_cnt"}, 64'(s_lc), 64'd0);
    chk({tag, " single"}, 64'(s_single), 64'd0);
  endtask

  function automatic vec_t mkv(bit dut, bit drop, bit z,
      logic [7:0][CW-1:0] cnt, logic [7:0] live,
      int l1i, logic [CW-1:0] l1v, int l2i, logic [CW-1:0] l2v,
      logic [63:0] sum, int lc, bit single,
      int nw, int w0, int w1, int done);
    vec_t v;
    v.dut = dut; v.drop = drop; v.zs = z; v.cnt = cnt; v.live = live;
    v.l1i = l1i; v.l1v = l1v; v.l2i = l2i; v.l2v = l2v;
    v.sum = sum; v.lc = lc; v.single = single;
    v.nw = nw; v.w0 = w0; v.w1 = w1; v.done = done;
    return v;
  endfunction

  task automatic run_vec(input int n, input vec_t v);
    int c, nrd, addr_err, clash, nw, done_c;
    int wl[4];
    bit seen;
    string p;
    p = $sformatf("v%0d", n);
    mem = v.cnt; mlive = v.live; zs = v.zs; sel = v.dut;
    @(negedge clk);
    if (v.dut) start1 = 1'b1; else start0 = 1'b1;
    @(posedge clk);
    #1 start0 = 1'b0; start1 = 1'b0;
    c = 1; nrd = 0; addr_err = 0; clash = 0; nw = 0;
    done_c = -1; seen = 1'b0;
    while (!seen && c < 60) begin
      @(negedge clk);
      if (s_rd_en) begin
        if (int'(s_rd_addr) != nrd) addr_err++;
        nrd++;
      end
      if (s_wipe_en) begin
        if (s_rd_en) clash++;
        if (nw < 4) wl[nw] = int'(s_wipe_addr);
        nw++;
      end
      if (s_done) begin
        seen = 1'b1;
        done_c = c;
      end
      if (v.drop) begin
        if (c == 3) en = 1'b0;
        if (c == 5) en = 1'b1;
        if (c == 6) start1 = 1'b1;
        if (c == 7) start1 = 1'b0;
      end
      c++;
    end
    chk({p, " done_seen"}, 64'(seen), 64'd1);
    chk({p, " done_cycle"}, 64'(done_c), 64'(v.done));
    chk({p, " reads"}, 64'(nrd), 64'(DEPTH));
    chk({p, " addr_seq_errs"}, 64'(addr_err), 64'd0);
    chk({p, " wipe_rd_clash"}, 64'(clash), 64'd0);
    chk({p, " n_wipes"}, 64'(nw), 64'(v.nw));
    if (v.nw > 0 && nw > 0) chk({p, " wipe0"}, 64'(wl[0]), 64'(v.w0));
    if (v.nw > 1 && nw > 1) chk({p, " wipe1"}, 64'(wl[1]), 64'(v.w1));
    chk({p, " l1i"}, 64'(s_l1i), 64'(v.l1i));
    chk({p, " l1v"}, 64'(s_l1v), 64'(v.l1v));
    chk({p, " l2i"}, 64'(s_l2i), 64'(v.l2i));
    chk({p, " l2v"}, 64'(s_l2v), 64'(v.l2v));
    chk({p, " sum"}, 64'(s_sum), v.sum);
    chk({p, " live_cnt"}, 64'(s_lc), 64'(v.lc));
    chk({p, " single"}, 64'(s_single), 64'(v.single));
    @(negedge clk);
    chk({p, " done_pulse_end"}, 64'(s_done), 64'd0);
    chk({p, " busy_end"}, 64'(s_busy), 64'd0);
    chk({p, " hold_sum"}, 64'(s_sum), v.sum);
  endtask

  localparam logic [7:0][CW-1:0] D0 =
    {32'd8, 32'd1, 32'd7, 32'd0, 32'd3, 32'd9, 32'd3, 32'd5};
  localparam logic [7:0][CW-1:0] D1 =
    {32'd8, 32'd1, 32'd7, 32'd0, 32'd3, 32'd42, 32'd3, 32'd5};
  localparam logic [7:0][CW-1:0] D2 =
    {32'd4, 32'd4, 32'd4, 32'd4, 32'd4, 32'd4, 32'd4, 32'd4};
  localparam logic [7:0][CW-1:0] D3 =
    {32'd1, 32'd1, 32'd1, 32'd1, 32'd1, 32'd1,
     32'hFFFFFFFE, 32'hFFFFFFFF};
  localparam logic [CW-1:0] ONES = 32'hFFFFFFFF;

  initial begin
    vt[0] = mkv(0, 0, 1, D0, 8'hFF, 6, 1, 1, 3, 4, 7, 0, 2, 6, 1, 12);
    vt[1] = mkv(0, 0, 0, D0, 8'hFF, 4, 0, 6, 1, 1, 8, 0, 2, 4, 6, 12);
    vt[2] = mkv(0, 0, 0, D1, 8'h04, 2, 42, 7, ONES, 42, 1, 1,
                1, 2, 0, 12);
    vt[3] = mkv(0, 0, 1, D0, 8'h00, 7, ONES, 7, ONES, 0, 0, 0,
                0, 0, 0, 12);
    vt[4] = mkv(0, 0, 0, D2, 8'hFF, 0, 4, 1, 4, 8, 8, 0, 2, 0, 1, 12);
    vt[5] = mkv(0, 0, 1, D3, 8'h03, 1, 32'hFFFFFFFE, 0, ONES,
                64'h1FFFFFFFD, 2, 0, 2, 1, 0, 12);
    vt[6] = mkv(1, 1, 1, D0, 8'hFF, 6, 1, 1, 3, 4, 7, 0, 2, 6, 1, 16);
    vt[7] = mkv(1, 0, 0, D0, 8'hFF, 4, 0, 6, 1, 1, 8, 0, 2, 4, 6, 14);

    nrst = 1'b0; en = 1'b1; zs = 1'b0; start0 = 1'b0; start1 = 1'b0;
    sel = 1'b0; mem = D0; mlive = 8'hFF;
    repeat (3) @(negedge clk);
    chk_reset("rst0");
    sel = 1'b1;
    #1 chk_reset("rst1");
    @(negedge clk);
    nrst = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 8; i++) run_vec(i, vt[i]);

    // Reset asserted in the middle of a read sweep.
    sel = 1'b0; mem = D0; mlive = 8'hFF; zs = 1'b1;
    @(negedge clk);
    start0 = 1'b1;
    @(posedge clk);
    #1 start0 = 1'b0;
    repeat (4) @(negedge clk);
    chk("mid busy_before", 64'(s_busy), 64'd1);
    chk("mid lc_before", 64'(s_lc), 64'd2);
    nrst = 1'b0;
    #1 chk_reset("midrst");
    @(negedge clk);
    nrst = 1'b1;
    @(negedge clk);
    run_vec(8, vt[0]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/t05_least_pair_scanner.md
# t05_least_pair_scanner

Parametrised successor to the Huffman least-value finder. On each `start` it scans a DEPTH-entry count memory (histogram/node SRAM) through a fixed-latency read port. It returns the two smallest live counts with their indices and sum, then issues wipe strobes that retire both winners. It sits between the histogram/node SRAM and the tree builder; the controller calls it once per tree-merge step.

## Interface
- DEPTH, 512: number of entries scanned (256 leaves + internal nodes); IDX_W = $clog2(DEPTH).
- CNT_W, 32: count width.
- RD_LAT, 1: read latency in cycles, ≥1.
- clk  in  1  system clock.
- nrst  in  1  reset; one clock, asynchronous, active-low.
- en  in  1  chip enable; low freezes FSM (no new reads, no state advance).
- start  in  1  begin a scan; sampled only in IDLE with en=1.
- zero_skip  in  1  mode; when 1, live entries with count 0 are ignored. Sampled at start.
- rd_en  out  1  read request.
- rd_addr  out  IDX_W  read address.
- rd_data  in  CNT_W  count, valid RD_LAT cycles after rd_en.
- rd_live  in  1  entry-not-consumed flag, aligned with rd_data.
- wipe_en  out  1  one-cycle strobe: mark wipe_addr consumed.
- wipe_addr  out  IDX_W  entry to retire.
- least1_idx, least2_idx  out  IDX_W  smallest / second-smallest index.
- least1_val, least2_val  out  CNT_W  their counts.
- sum  out  CNT_W+1  least1_val+least2_val; no overflow possible.
- live_cnt  out  IDX_W+1  number of qualifying entries seen.
- single  out  1  exactly one qualifying entry (tree root reached).
- busy  out  1  high outside IDLE.
- done  out  1  one-cycle pulse, results valid.

## Operation
- States: IDLE → READ → DRAIN → WIPE1 → WIPE2 → DONE → IDLE.
- IDLE: start&en → READ. All result registers are cleared: idx = all-ones, val = all-ones, sum = 0, live_cnt = 0, single = 0.
- READ: rd_en=1, rd_addr = 0,1,…,DEPTH-1, one per en-high cycle. After DEPTH-1 is issued → DRAIN.
- DRAIN: waits RD_LAT en-high cycles → WIPE1.
- Return pipeline: a shift register of {valid, addr} of depth RD_LAT. It advances every cycle regardless of en, so in-flight returns are never lost.
- Qualifying entry: rd_live=1 and !(zero_skip && rd_data==0).
- Update on each qualifying return v at address a:
  - If no entry found yet, or v < l1: l2 ← l1, l1 ← (v,a).
  - Else if fewer than 2 found, or v < l2: l2 ← (v,a).
  - Strict compare, so ties keep the lower address.
  - live_cnt increments by 1.
- WIPE1: if live_cnt ≥ 1, wipe_en=1, wipe_addr=least1_idx; otherwise no strobe.
- WIPE2: if live_cnt ≥ 2, wipe_en=1, wipe_addr=least2_idx; otherwise no strobe.
- DONE: done=1 for one cycle.
  - sum = l1+l2 when live_cnt ≥ 2, l1 when live_cnt = 1, 0 when live_cnt = 0.
  - single = (live_cnt==1).
- Results hold until the next accepted start.
- start while busy: ignored.

## Timing
- Reset: state IDLE; all outputs 0 except idx/val all-ones; rd_en = wipe_en = done = busy = 0.
- Reset mid-scan: immediate return to IDLE; the in-flight pipeline is flushed.
- start sampled at edge 0 → rd_addr 0 is driven in cycle 1; the last read is in cycle DEPTH.
- DRAIN occupies cycles DEPTH+1 … DEPTH+RD_LAT; WIPE1 at +1, WIPE2 at +2, done at DEPTH+RD_LAT+3 (en held high).
- Each en-low cycle adds exactly one cycle of latency. rd_en=0 and wipe_en=0 while en=0.
- wipe_en is never asserted in the same cycle as rd_en.
- All outputs are registered.

## Test plan
- DEPTH=8, RD_LAT=1, counts {5,3,9,3,0,7,1,8}, all live, zero_skip=1:
  - least1=(6,1), least2=(1,3), sum=4, live_cnt=7.
  - wipes to 6 then 1; done at cycle 12.
- Same data, zero_skip=0:
  - least1=(4,0), least2=(6,1), sum=1, live_cnt=8.
- Only entry 2 live (count 42):
  - single=1, sum=42, least2_idx all-ones.
  - one wipe to addr 2.
- No live entries:
  - live_cnt=0, no wipe_en, done still pulses.
- RD_LAT=3, en dropped for 2 cycles mid-READ:
  - results identical to the en-high run; done arrives 2 cycles later (DEPTH+RD_LAT+5).
  - start pulsed while busy is ignored.
- nrst asserted mid-READ:
  - outputs return to reset values asynchronously.
  - a subsequent start completes normally.
